nfc_physical_output_pipe: RTL and testbench
===========================================

# nfc_physical_output_pipe

Parametrised, registered output stage of the NAND flash PHY. It sits between the controller's timing generator and the DDR output primitives. It delays all NAND control and data lanes through a configurable pipeline and produces per-signal rise/fall lane pairs for the DDR primitives. It also owns DQ/DQS bus-direction control, including a programmable turnaround guard, an SDR/DDR lane mode, and a sticky chip-enable protocol check.

## Interface
Parameters:
- NumberOfWays, 4, number of CE lines (1..8)
- DQWidth, 8, DQ bus width (8 or 16)
- PipeDepth, 2, register stages from inputs to outputs (1..4)
- TurnaroundCycles, 1, guard cycles between an output-enable request and the bus being driven (0..7)

Ports:
- iSystemClock  in  1  sole clock; all state on rising edge
- iModuleResetN  in  1  asynchronous, active-low reset
- iDQSOutEnable  in  1  request to drive DQS
- iDQOutEnable  in  1  request to drive DQ
- iSDRMode  in  1  1: each fall lane copies its rise lane (SDR); 0: DDR
- iPO_DQStrobe  in  2  [0] rise, [1] fall
- iPO_DQ  in  2*DQWidth  [DQWidth-1:0] rise, upper half fall
- iPO_ChipEnable  in  NumberOfWays  active-low CE per way
- iPO_ReadEnable, iPO_WriteEnable, iPO_AddressLatchEnable, iPO_CommandLatchEnable  in  2 each  [0] rise, [1] fall
- oDQS_Rise, oDQS_Fall  out  1 each  DQS lanes
- oDQ_Rise, oDQ_Fall  out  DQWidth each  DQ lanes
- oDQSTristate  out  1  1 = DQS pad tristated
- oDQTristate  out  DQWidth  1 = DQ pad tristated, replicated per bit
- oCE  out  NumberOfWays  CE to pads
- oRE_Rise/oRE_Fall, oWE_Rise/oWE_Fall, oALE_Rise/oALE_Fall, oCLE_Rise/oCLE_Fall  out  1 each
- oTurnaroundBusy  out  1  either direction FSM in WAIT
- oProtocolError  out  1  sticky CE violation flag

## Operation
- **Pipeline:** every input, including iSDRMode and both enables, passes through PipeDepth register stages. Output lanes are the final stage.
- **SDR mode:** applied at stage 1 using the stage-1 iSDRMode. When 1, every fall lane is loaded with its rise-lane value (DQ, DQS, RE, WE, ALE, CLE). CE is single-lane and is unaffected.
- **Direction FSMs:** two independent instances, one for DQ and one for DQS. Each FSM's input is its enable delayed by PipeDepth-1 stages (the raw enable when PipeDepth=1).
  - States: HIZ, WAIT, DRIVE.
  - HIZ → DRIVE when enable=1 and TurnaroundCycles=0.
  - HIZ → WAIT when enable=1 and TurnaroundCycles>0; the counter loads TurnaroundCycles-1.
  - WAIT: while enable=1, the counter decrements; WAIT → DRIVE when the counter is 0.
  - WAIT or DRIVE → HIZ on enable=0, with no guard.
  - Tristate output = 0 only in DRIVE.
- **Data during WAIT:** keeps flowing to the lanes; only the pad stays tristated.
- **Protocol check:** oProtocolError sets when more than one bit of the final-stage CE is 0 in the same cycle. It clears only on reset.

## Timing
- **Reset values**, applied asynchronously to outputs and every pipeline stage:
  - DQ and DQS lanes 0; oDQTristate and oDQSTristate all 1.
  - oCE all 1; RE and WE lanes 1; ALE and CLE lanes 0.
  - oTurnaroundBusy 0; oProtocolError 0; FSMs in HIZ.
- **Data latency:** a value on an input at edge N appears on its lane after edge N+PipeDepth-1, i.e. PipeDepth edges.
- **Tristate release** (enable rising, then held high):
  - TurnaroundCycles=0: tristate falls on the same cycle the first enabled data appears.
  - Otherwise: tristate falls TurnaroundCycles cycles later.
- **Tristate reassert:** rises on the same cycle as the first sample taken with the enable low.
- **Enable drops in WAIT:** return to HIZ and discard the counter. A new request restarts the full guard.
- **Simultaneous transitions:** DQ and DQS FSMs act independently. oTurnaroundBusy is the OR of both WAIT states.
- **Reset mid-operation:** all outputs go idle immediately. After release, outputs hold idle values for PipeDepth cycles while the pipeline refills.

## Test plan
- **Reset idle:** assert iModuleResetN=0 mid-burst with PipeDepth=2 → all outputs take reset values immediately; after release, DQ lanes stay 0 for 2 cycles.
- **DDR latency:** iPO_DQ=16'hA55A, iSDRMode=0, PipeDepth=3 → oDQ_Rise=8'h5A and oDQ_Fall=8'hA5 exactly 3 edges later.
- **SDR copy:** iSDRMode=1, iPO_WriteEnable=2'b10 → oWE_Rise=0 and oWE_Fall=0 after PipeDepth edges.
- **Turnaround guard:** TurnaroundCycles=3, iDQOutEnable held 1 → oTurnaroundBusy=1 for 3 cycles, then oDQTristate=0.
  - Variant: drop the enable after 1 guard cycle → returns to HIZ with no drive.
- **Fast release:** TurnaroundCycles=0, DQ enable toggled 1 → 0 → oDQTristate falls and rises aligned with the first enabled and first disabled data samples.
- **CE check:** NumberOfWays=4, iPO_ChipEnable=4'b1100 for one cycle → oProtocolError=1 after PipeDepth edges and stays 1 until reset; 4'b1110 alone never sets it.

Source files
------------

// File: rtl/nfc_physical_output_pipe_if.sv
// Bus bundle between the NAND timing generator and the PHY output stage.
// The slave side is the output pipe. The master side is the controller or the bench.
interface nfc_physical_output_pipe_if #(
  parameter int NumberOfWays = 4,
  parameter int DQWidth      = 8
);
  logic                      iDQSOutEnable;
  logic                      iDQOutEnable;
  logic                      iSDRMode;
  logic [1:0]                iPO_DQStrobe;
  logic [2*DQWidth-1:0]      iPO_DQ;
  logic [NumberOfWays-1:0]   iPO_ChipEnable;
  logic [1:0]                iPO_ReadEnable;
  logic [1:0]                iPO_WriteEnable;
  logic [1:0]                iPO_AddressLatchEnable;
  logic [1:0]                iPO_CommandLatchEnable;

  logic                      oDQS_Rise;
  logic                      oDQS_Fall;
  logic [DQWidth-1:0]        oDQ_Rise;
  logic [DQWidth-1:0]        oDQ_Fall;
  logic                      oDQSTristate;
  logic [DQWidth-1:0]        oDQTristate;
  logic [NumberOfWays-1:0]   oCE;
  logic                      oRE_Rise;
  logic                      oRE_Fall;
  logic                      oWE_Rise;
  logic                      oWE_Fall;
  logic                      oALE_Rise;
  logic                      oALE_Fall;
  logic                      oCLE_Rise;
  logic                      oCLE_Fall;
  logic                      oTurnaroundBusy;
  logic                      oProtocolError;

  modport slave (
    input  iDQSOutEnable, iDQOutEnable, iSDRMode, iPO_DQStrobe, iPO_DQ, iPO_ChipEnable,
           iPO_ReadEnable, iPO_WriteEnable, iPO_AddressLatchEnable, iPO_CommandLatchEnable,
    output oDQS_Rise, oDQS_Fall, oDQ_Rise, oDQ_Fall, oDQSTristate, oDQTristate, oCE,
           oRE_Rise, oRE_Fall, oWE_Rise, oWE_Fall, oALE_Rise, oALE_Fall, oCLE_Rise, oCLE_Fall,
           oTurnaroundBusy, oProtocolError
  );

  modport master (
    output iDQSOutEnable, iDQOutEnable, iSDRMode, iPO_DQStrobe, iPO_DQ, iPO_ChipEnable,
           iPO_ReadEnable, iPO_WriteEnable, iPO_AddressLatchEnable, iPO_CommandLatchEnable,
    input  oDQS_Rise, oDQS_Fall, oDQ_Rise, oDQ_Fall, oDQSTristate, oDQTristate, oCE,
           oRE_Rise, oRE_Fall, oWE_Rise, oWE_Fall, oALE_Rise, oALE_Fall, oCLE_Rise, oCLE_Fall,
           oTurnaroundBusy, oProtocolError
  );
endinterface

// File: rtl/nfc_physical_output_pipe.sv
// Registered NAND PHY output stage: delays all lanes, folds SDR onto rise lanes,
// drives DQ/DQS direction with a turnaround guard, and flags illegal multi-CE selects.
module nfc_physical_output_pipe #(
  parameter int NumberOfWays     = 4,
  parameter int DQWidth          = 8,
  parameter int PipeDepth        = 2,
  parameter int TurnaroundCycles = 1
) (
  input logic                   iSystemClock,
  input logic                   iModuleResetN,
  nfc_physical_output_pipe_if.slave phy
);

  typedef struct packed {
    logic [1:0]              dqs;
    logic [2*DQWidth-1:0]    dq;
    logic [NumberOfWays-1:0] ce;
    logic [1:0]              re;
    logic [1:0]              we;
    logic [1:0]              ale;
    logic [1:0]              cle;
  } lanes_t;

  typedef enum logic [1:0] {StHiz, StWait, StDrive} dirState_t;

  localparam lanes_t IdleLanes = '{dqs: 2'b00, dq: {(2*DQWidth){1'b0}},
                                   ce: {NumberOfWays{1'b1}}, re: 2'b11, we: 2'b11,
                                   ale: 2'b00, cle: 2'b00};
  localparam int GuardLoad = (TurnaroundCycles > 0) ? TurnaroundCycles - 1 : 0;

  function automatic logic [1:0] sdrFold(input logic sdr, input logic [1:0] lane);
    return sdr ? {lane[0], lane[0]} : lane;
  endfunction

  function automatic logic multipleLow(input logic [NumberOfWays-1:0] ce);
    return $countones(~ce) > 1;
  endfunction

  lanes_t    firstStage;
  lanes_t    lastIn;
  lanes_t    outLanes;
  lanes_t    pipe [PipeDepth];
  logic      protocolError;
  logic [1:0] fsmEn;
  dirState_t state [2];
  dirState_t nextState [2];
  logic [2:0] cnt [2];
  logic [2:0] nextCnt [2];

  always_comb begin
    firstStage     = IdleLanes;
    firstStage.dqs = sdrFold(phy.iSDRMode, phy.iPO_DQStrobe);
    firstStage.dq  = phy.iSDRMode ? {2{phy.iPO_DQ[DQWidth-1:0]}} : phy.iPO_DQ;
    firstStage.ce  = phy.iPO_ChipEnable;
    firstStage.re  = sdrFold(phy.iSDRMode, phy.iPO_ReadEnable);
    firstStage.we  = sdrFold(phy.iSDRMode, phy.iPO_WriteEnable);
    firstStage.ale = sdrFold(phy.iSDRMode, phy.iPO_AddressLatchEnable);
    firstStage.cle = sdrFold(phy.iSDRMode, phy.iPO_CommandLatchEnable);
  end

  // Direction enables run one stage short so the FSM register lands with the data.
  generate
    if (PipeDepth == 1) begin : gNoEnDelay
      assign lastIn = firstStage;
      assign fsmEn  = {phy.iDQSOutEnable, phy.iDQOutEnable};
    end else begin : gEnDelay
      logic [1:0] enDly [PipeDepth-1];
      assign lastIn = pipe[PipeDepth-2];
      assign fsmEn  = enDly[PipeDepth-2];
      always_ff @(posedge iSystemClock or negedge iModuleResetN) begin
        if (!iModuleResetN) begin
          for (int k = 0; k < PipeDepth-1; k++) enDly[k] <= 2'b00;
        end else begin
          enDly[0] <= {phy.iDQSOutEnable, phy.iDQOutEnable};
          for (int k = 1; k < PipeDepth-1; k++) enDly[k] <= enDly[k-1];
        end
      end
    end
  endgenerate

  // Lane pipeline; the CE check looks at what is entering the final stage.
  always_ff @(posedge iSystemClock or negedge iModuleResetN) begin
    if (!iModuleResetN) begin
      for (int k = 0; k < PipeDepth; k++) pipe[k] <= IdleLanes;
      protocolError <= 1'b0;
    end else begin
      pipe[0] <= firstStage;
      for (int k = 1; k < PipeDepth; k++) pipe[k] <= pipe[k-1];
      if (multipleLow(lastIn.ce)) protocolError <= 1'b1;
    end
  end

  // Direction FSMs: index 0 is DQ, index 1 is DQS.
  always_ff @(posedge iSystemClock or negedge iModuleResetN) begin
    if (!iModuleResetN) begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= StHiz;
        cnt[i]   <= 3'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= nextState[i];
        cnt[i]   <= nextCnt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      nextState[i] = state[i];
      nextCnt[i]   = cnt[i];
      case (state[i])
        StHiz: begin
          if (fsmEn[i]) begin
            if (TurnaroundCycles == 0) begin
              nextState[i] = StDrive;
            end else begin
              nextState[i] = StWait;
              nextCnt[i]   = 3'(GuardLoad);
            end
          end
        end
        StWait: begin
          if (!fsmEn[i])          nextState[i] = StHiz;
          else if (cnt[i] == 3'd0) nextState[i] = StDrive;
          else                     nextCnt[i]   = cnt[i] - 3'd1;
        end
        StDrive: begin
          if (!fsmEn[i]) nextState[i] = StHiz;
        end
        default: nextState[i] = StHiz;
      endcase
    end
  end

  assign outLanes = pipe[PipeDepth-1];

  assign phy.oDQS_Rise       = outLanes.dqs[0];
  assign phy.oDQS_Fall       = outLanes.dqs[1];
  assign phy.oDQ_Rise        = outLanes.dq[DQWidth-1:0];
  assign phy.oDQ_Fall        = outLanes.dq[2*DQWidth-1:DQWidth];
  assign phy.oCE             = outLanes.ce;
  assign phy.oRE_Rise        = outLanes.re[0];
  assign phy.oRE_Fall        = outLanes.re[1];
  assign phy.oWE_Rise        = outLanes.we[0];
  assign phy.oWE_Fall        = outLanes.we[1];
  assign phy.oALE_Rise       = outLanes.ale[0];
  assign phy.oALE_Fall       = outLanes.ale[1];
  assign phy.oCLE_Rise       = outLanes.cle[0];
  assign phy.oCLE_Fall       = outLanes.cle[1];
  assign phy.oDQTristate     = {DQWidth{state[0] != StDrive}};
  assign phy.oDQSTristate    = (state[1] != StDrive);
  assign phy.oTurnaroundBusy = (state[0] == StWait) || (state[1] == StWait);
  assign phy.oProtocolError  = protocolError;

endmodule

// File: tb/tb_nfc_physical_output_pipe.sv
// Directed bench: instance A (PipeDepth=3, guard=3) and instance B (PipeDepth=2, guard=0).
module tb_nfc_physical_output_pipe;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  int   nChecks = 0;
  int   nPass   = 0;

  always #5 clk = ~clk;

  nfc_physical_output_pipe_if #(.NumberOfWays(4), .DQWidth(8)) ifA ();
  nfc_physical_output_pipe_if #(.NumberOfWays(4), .DQWidth(8)) ifB ();

  nfc_physical_output_pipe #(
    .NumberOfWays(4), .DQWidth(8), .PipeDepth(3), .TurnaroundCycles(3)
  ) dutA (
    .iSystemClock(clk), .iModuleResetN(rstA), .phy(ifA)
  );

  nfc_physical_output_pipe #(
    .NumberOfWays(4), .DQWidth(8), .PipeDepth(2), .TurnaroundCycles(0)
  ) dutB (
    .iSystemClock(clk), .iModuleResetN(rstB), .phy(ifB)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idleA();
    ifA.iDQSOutEnable = 1'b0;  ifA.iDQOutEnable = 1'b0;  ifA.iSDRMode = 1'b0;
    ifA.iPO_DQStrobe = 2'b00;  ifA.iPO_DQ = 16'h0000;    ifA.iPO_ChipEnable = 4'hF;
    ifA.iPO_ReadEnable = 2'b11; ifA.iPO_WriteEnable = 2'b11;
    ifA.iPO_AddressLatchEnable = 2'b00; ifA.iPO_CommandLatchEnable = 2'b00;
  endtask

  task automatic idleB();
    ifB.iDQSOutEnable = 1'b0;  ifB.iDQOutEnable = 1'b0;  ifB.iSDRMode = 1'b0;
    ifB.iPO_DQStrobe = 2'b00;  ifB.iPO_DQ = 16'h0000;    ifB.iPO_ChipEnable = 4'hF;
    ifB.iPO_ReadEnable = 2'b11; ifB.iPO_WriteEnable = 2'b11;
    ifB.iPO_AddressLatchEnable = 2'b00; ifB.iPO_CommandLatchEnable = 2'b00;
  endtask

  task automatic checkIdleA(input string tag);
    checkEq({tag, "/lanes"},
            {ifA.oDQ_Rise, ifA.oDQ_Fall, ifA.oDQS_Rise, ifA.oDQS_Fall, ifA.oRE_Rise, ifA.oRE_Fall,
             ifA.oWE_Rise, ifA.oWE_Fall, ifA.oALE_Rise, ifA.oALE_Fall, ifA.oCLE_Rise, ifA.oCLE_Fall},
            {16'h0000, 2'b00, 4'b1111, 4'b0000});
    checkEq({tag, "/ctrl"},
            {ifA.oDQTristate, ifA.oDQSTristate, ifA.oCE, ifA.oTurnaroundBusy, ifA.oProtocolError},
            {8'hFF, 1'b1, 4'hF, 2'b00});
  endtask

  task automatic checkIdleB(input string tag);
    checkEq({tag, "/lanes"},
            {ifB.oDQ_Rise, ifB.oDQ_Fall, ifB.oDQS_Rise, ifB.oDQS_Fall, ifB.oRE_Rise, ifB.oRE_Fall,
             ifB.oWE_Rise, ifB.oWE_Fall, ifB.oALE_Rise, ifB.oALE_Fall, ifB.oCLE_Rise, ifB.oCLE_Fall},
            {16'h0000, 2'b00, 4'b1111, 4'b0000});
    checkEq({tag, "/ctrl"},
            {ifB.oDQTristate, ifB.oDQSTristate, ifB.oCE, ifB.oTurnaroundBusy, ifB.oProtocolError},
            {8'hFF, 1'b1, 4'hF, 2'b00});
  endtask

  // Enable held from now: busy for three cycles starting at the third edge, drive at the sixth.
  task automatic guardRunA(input string tag);
    ifA.iDQOutEnable = 1'b1;
    tick(2);
    checkEq({tag, "/pre"}, {ifA.oTurnaroundBusy, ifA.oDQTristate}, {1'b0, 8'hFF});
    for (int c = 0; c < 3; c++) begin
      tick(1);
      checkEq($sformatf("%s/wait%0d", tag, c), {ifA.oTurnaroundBusy, ifA.oDQTristate}, {1'b1, 8'hFF});
    end
    tick(1);
    checkEq({tag, "/drive"}, {ifA.oTurnaroundBusy, ifA.oDQTristate, ifA.oDQSTristate},
            {1'b0, 8'h00, 1'b1});
  endtask

  initial begin
    rstA = 1'b0;
    rstB = 1'b0;
    idleA();
    idleB();
    tick(2);
    checkIdleA("rstA");
    checkIdleB("rstB");
    @(negedge clk);
    rstA = 1'b1;
    rstB = 1'b1;
    tick(1);

    // DDR latency: single-cycle pulse must appear exactly three edges later
    ifA.iPO_DQ = 16'hA55A;
    ifA.iPO_DQStrobe = 2'b10;
    tick(1);
    ifA.iPO_DQ = 16'h0000;
    ifA.iPO_DQStrobe = 2'b00;
    tick(1);
    checkEq("ddr/early", {ifA.oDQ_Rise, ifA.oDQ_Fall}, 16'h0000);
    tick(1);
    checkEq("ddr/dq", {ifA.oDQ_Fall, ifA.oDQ_Rise}, 16'hA55A);
    checkEq("ddr/dqs", {ifA.oDQS_Fall, ifA.oDQS_Rise}, 2'b10);
    tick(1);
    checkEq("ddr/after", {ifA.oDQ_Rise, ifA.oDQ_Fall}, 16'h0000);

    // SDR: fall lanes copy rise lanes
    ifA.iSDRMode = 1'b1;
    ifA.iPO_WriteEnable = 2'b10;
    ifA.iPO_DQ = 16'hA55A;
    tick(3);
    checkEq("sdr/we", {ifA.oWE_Rise, ifA.oWE_Fall}, 2'b00);
    checkEq("sdr/dq", {ifA.oDQ_Fall, ifA.oDQ_Rise}, 16'h5A5A);
    idleA();
    tick(3);
    checkEq("sdr/restore", {ifA.oWE_Rise, ifA.oWE_Fall, ifA.oDQ_Rise}, {2'b11, 8'h00});

    // Turnaround guard of 3 cycles, then release
    guardRunA("guard");
    ifA.iDQOutEnable = 1'b0;
    tick(2);
    checkEq("guard/holdDrive", ifA.oDQTristate, 8'h00);
    tick(1);
    checkEq("guard/hiz", ifA.oDQTristate, 8'hFF);

    // Enable dropped after one guard cycle: back to HIZ, no drive
    ifA.iDQOutEnable = 1'b1;
    tick(2);
    ifA.iDQOutEnable = 1'b0;
    tick(1);
    checkEq("abort/wait0", ifA.oTurnaroundBusy, 1'b1);
    tick(1);
    checkEq("abort/wait1", ifA.oTurnaroundBusy, 1'b1);
    tick(1);
    checkEq("abort/hiz", {ifA.oTurnaroundBusy, ifA.oDQTristate}, {1'b0, 8'hFF});
    for (int c = 0; c < 3; c++) begin
      tick(1);
      checkEq($sformatf("abort/stay%0d", c), {ifA.oTurnaroundBusy, ifA.oDQTristate}, {1'b0, 8'hFF});
    end
    guardRunA("restart");

    // Reset mid-burst on B
    ifB.iDQOutEnable = 1'b1;
    ifB.iPO_DQ = 16'h5634;
    ifB.iPO_ChipEnable = 4'b1110;
    ifB.iPO_ReadEnable = 2'b01;
    tick(2);
    checkEq("burst/active", {ifB.oDQ_Rise, ifB.oDQTristate, ifB.oCE, ifB.oRE_Rise, ifB.oRE_Fall},
            {8'h34, 8'h00, 4'b1110, 2'b10});
    #2 rstB = 1'b0;
    #1 checkIdleB("midrst");
    @(posedge clk);
    #3 rstB = 1'b1;
    checkEq("refill/0", ifB.oDQ_Rise, 8'h00);
    tick(1);
    checkEq("refill/1", {ifB.oDQ_Rise, ifB.oDQTristate}, {8'h00, 8'hFF});
    tick(1);
    checkEq("refill/2", {ifB.oDQ_Rise, ifB.oDQTristate}, {8'h34, 8'h00});

    // Fast release with zero guard: tristate aligned with data
    ifB.iDQOutEnable = 1'b0;
    ifB.iPO_DQ = 16'h0000;
    tick(3);
    checkEq("fast/idle", ifB.oDQTristate, 8'hFF);
    ifB.iDQOutEnable = 1'b1;
    ifB.iPO_DQ = 16'h0077;
    tick(1);
    checkEq("fast/on0", {ifB.oDQ_Rise, ifB.oDQTristate}, {8'h00, 8'hFF});
    tick(1);
    checkEq("fast/on1", {ifB.oDQ_Rise, ifB.oDQTristate, ifB.oDQSTristate, ifB.oTurnaroundBusy},
            {8'h77, 8'h00, 1'b1, 1'b0});
    ifB.iDQOutEnable = 1'b0;
    ifB.iPO_DQ = 16'h0011;
    tick(1);
    checkEq("fast/off0", {ifB.oDQ_Rise, ifB.oDQTristate}, {8'h77, 8'h00});
    tick(1);
    checkEq("fast/off1", {ifB.oDQ_Rise, ifB.oDQTristate}, {8'h11, 8'hFF});

    // CE protocol check: single way legal, two ways illegal and sticky
    ifB.iPO_ChipEnable = 4'b1110;
    tick(3);
    checkEq("ce/single", {ifB.oCE, ifB.oProtocolError}, {4'b1110, 1'b0});
    ifB.iPO_ChipEnable = 4'b1100;
    tick(1);
    ifB.iPO_ChipEnable = 4'b1111;
    checkEq("ce/early", ifB.oProtocolError, 1'b0);
    tick(1);
    checkEq("ce/set", {ifB.oCE, ifB.oProtocolError}, {4'b1100, 1'b1});
    tick(3);
    checkEq("ce/sticky", {ifB.oCE, ifB.oProtocolError}, {4'b1111, 1'b1});
    rstB = 1'b0;
    #2 checkEq("ce/clear", ifB.oProtocolError, 1'b0);
    rstB = 1'b1;
    tick(2);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
